// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops, iterative Booth multiply and
// optional non-restoring divide (enabled by defining ALU_MC_DIV_EN).
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero,
    output logic                 illegal_op,
    output logic [1:0]           dbg_state
);

    // Handshake: an operation is taken on a rising edge where in_valid && in_ready;
    // a result is consumed on a rising edge where out_valid && out_ready, and
    // result/flags stay constant from out_valid rising until that edge.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SHR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_ROL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1001;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CW-1:0]      cnt;
    // Shared iteration registers: Booth {acc, qreg, qm1} or divider {remainder, quotient}
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   qreg;
    logic               qm1;
    logic [WIDTH-1:0]   mcand;

    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH-1:0] fin_result;
    logic               fin_dbz, fin_ill;
    logic [WIDTH-1:0]   lo, rot_amt;
    logic [2*WIDTH-1:0] ror_w, rol_w;
    logic               wide;

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;
    assign mcand_ext = {mcand[WIDTH-1], mcand};

    always_comb begin
        case ({qreg[0], qm1})
            2'b01:   booth_sum = acc + mcand_ext;
            2'b10:   booth_sum = acc - mcand_ext;
            default: booth_sum = acc;
        endcase
    end

`ifdef ALU_MC_DIV_EN
    // Divider runs on magnitudes; signs are reapplied when the result is latched.
    logic [WIDTH-1:0] a_abs, b_abs, div_quo, div_rem;
    logic [WIDTH:0]   div_shift, div_acc_n, rem_fix;

    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;

    always_comb begin
        div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        div_acc_n = acc[WIDTH] ? div_shift + {1'b0, mcand} : div_shift - {1'b0, mcand};
        rem_fix   = acc[WIDTH] ? acc + {1'b0, mcand} : acc;
        div_quo   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -qreg : qreg;
        div_rem   = a_q[WIDTH-1] ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
    end
`endif

    always_comb begin
        fin_result = '0;
        fin_dbz    = 1'b0;
        fin_ill    = 1'b0;
        wide       = 1'b0;
        lo         = '0;
        rot_amt    = b_q % WVAL;
        ror_w      = {a_q, a_q} >> rot_amt;
        rol_w      = {a_q, a_q} << rot_amt;
        case (op_q)
            OP_AND: lo = a_q & b_q;
            OP_OR:  lo = a_q | b_q;
            OP_ADD: lo = a_q + b_q;
            OP_SUB: lo = a_q - b_q;
            OP_SHR: lo = (b_q >= WVAL) ? '0 : a_q >> b_q;
            OP_SHL: lo = (b_q >= WVAL) ? '0 : a_q << b_q;
            OP_ROR: lo = ror_w[WIDTH-1:0];
            OP_ROL: lo = rol_w[2*WIDTH-1:WIDTH];
            OP_NEG: lo = -a_q;
            OP_NOT: lo = ~a_q;
            OP_MUL: begin
                wide       = 1'b1;
                fin_result = {acc[WIDTH-1:0], qreg};
            end
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
                wide = 1'b1;
                if (b_q == '0) begin
                    fin_result = {a_q, {WIDTH{1'b1}}};
                    fin_dbz    = 1'b1;
                end else begin
                    fin_result = {div_rem, div_quo};
                end
            end
`endif
            default: fin_ill = 1'b1;
        endcase
        if (!wide) fin_result = {{WIDTH{1'b0}}, lo};
    end

    // DONE has two phases: out_valid low (result being latched) then out_valid high.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            cnt         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            qreg        <= '0;
            qm1         <= 1'b0;
            mcand       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= '0;
                        acc   <= '0;
                        qm1   <= 1'b0;
                        state <= DONE;
                        if (op == OP_MUL) begin
                            qreg  <= a;
                            mcand <= b;
                            state <= BUSY;
                        end
`ifdef ALU_MC_DIV_EN
                        if (op == OP_DIV) begin
                            qreg  <= a_abs;
                            mcand <= b_abs;
                            state <= BUSY;
                        end
`endif
                    end
                end
                BUSY: begin
`ifdef ALU_MC_DIV_EN
                    if (op_q == OP_DIV) begin
                        acc  <= div_acc_n;
                        qreg <= {qreg[WIDTH-2:0], ~div_acc_n[WIDTH]};
                    end else
`endif
                    begin
                        acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
                        qm1  <= qreg[0];
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        result      <= fin_result;
                        div_by_zero <= fin_dbz;
                        illegal_op  <= fin_ill;
                        out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (WIDTH=32); divide vectors depend on ALU_MC_DIV_EN.
module tb_alu_mc;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clr_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     op = 4'd0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic           div_by_zero;
    logic           illegal_op;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero), .illegal_op(illegal_op),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (lat < 100 && !out_valid) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic op_check(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [63:0] exp_res,
                            input logic exp_dbz, input logic exp_ill, input int exp_lat);
        int lat;
        start_op(o, x, y);
        wait_valid(tag, lat);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        check({tag, "_ill"}, 64'(illegal_op), 64'(exp_ill));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_pop"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        int  lat;
        bit  seen;
        logic [63:0] held;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_flags", {62'd0, div_by_zero, illegal_op}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk) clr_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single-cycle ops
        op_check("add", 4'b0010, 32'd5, 32'hFFFF_FFFD, 64'h2, 1'b0, 1'b0, 1);
        op_check("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'hF000_F000, 1'b0, 1'b0, 1);
        op_check("or", 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'hFFF0_FFF0, 1'b0, 1'b0, 1);
        op_check("sub", 4'b0011, 32'd3, 32'd5, 64'hFFFF_FFFE, 1'b0, 1'b0, 1);
        op_check("shr4", 4'b0100, 32'h8000_0000, 32'd4, 64'h0800_0000, 1'b0, 1'b0, 1);
        op_check("shr40", 4'b0100, 32'h8000_0000, 32'd40, 64'h0, 1'b0, 1'b0, 1);
        op_check("shl32", 4'b0101, 32'd1, 32'd32, 64'h0, 1'b0, 1'b0, 1);
        op_check("shl3", 4'b0101, 32'd1, 32'd3, 64'h8, 1'b0, 1'b0, 1);
        op_check("ror1", 4'b0110, 32'h8000_0001, 32'd1, 64'hC000_0000, 1'b0, 1'b0, 1);
        op_check("ror33", 4'b0110, 32'h8000_0001, 32'd33, 64'hC000_0000, 1'b0, 1'b0, 1);
        op_check("rol1", 4'b0111, 32'h8000_0001, 32'd1, 64'h3, 1'b0, 1'b0, 1);
        op_check("rol0", 4'b0111, 32'h1234_5678, 32'd64, 64'h1234_5678, 1'b0, 1'b0, 1);
        op_check("neg", 4'b1010, 32'd5, 32'd99, 64'hFFFF_FFFB, 1'b0, 1'b0, 1);
        op_check("not", 4'b1011, 32'h0F0F_0000, 32'd7, 64'hF0F0_FFFF, 1'b0, 1'b0, 1);
        op_check("illegal", 4'b1100, 32'd5, 32'd6, 64'h0, 1'b0, 1'b1, 1);
        op_check("illegal_f", 4'b1111, 32'hFFFF_FFFF, 32'd6, 64'h0, 1'b0, 1'b1, 1);

        // Multiply
        op_check("mul_neg", 4'b1000, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 1'b0, 33);
        op_check("mul_min", 4'b1000, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 33);
        op_check("mul_pos", 4'b1000, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0, 33);
        op_check("mul_m1", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 33);

        // Divide
`ifdef ALU_MC_DIV_EN
        op_check("div_neg", 4'b1001, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 33);
        op_check("div_zero", 4'b1001, 32'd10, 32'd0, 64'h0000_000A_FFFF_FFFF, 1'b1, 1'b0, 33);
        op_check("div_pos", 4'b1001, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 1'b0, 33);
        op_check("div_nb", 4'b1001, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0, 33);
`else
        op_check("div_off", 4'b1001, 32'hFFFF_FFF9, 32'd2, 64'h0, 1'b0, 1'b1, 1);
        op_check("div_off_z", 4'b1001, 32'd10, 32'd0, 64'h0, 1'b0, 1'b1, 1);
`endif

        // Backpressure: result held, new requests ignored
        start_op(4'b0011, 32'd9, 32'd4);
        wait_valid("hold", lat);
        held = result;
        check("hold_first", held, 64'd5);
        for (int i = 0; i < 5; i++) begin
            op = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_res", result, 64'd5);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("hold_pop", {62'd0, out_valid, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (out_valid || dbg_state != 2'd0) seen = 1'b1;
        end
        check("hold_ignored", 64'(seen), 64'd0);

        // Reset during a multiply
        start_op(4'b1000, 32'd1234, 32'd77);
        repeat (10) @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_result", result, 64'd0);
        @(negedge clk) clr_n = 1'b1;
        #1 check("mid_rst_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("mid_rst_abandon", 64'(seen), 64'd0);
        op_check("post_rst_add", 4'b0010, 32'd7, 32'd8, 64'd15, 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand width in bits (even, 8..64).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: clr_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port: op  input  4  opcode: 0000 and, 0001 or, 0010 add, 0011 sub, 0100 shr, 0101 shl, 0110 ror, 0111 rol, 1000 mul, 1001 div, 1010 neg, 1011 not.
REQ-007 SHALL have ports: a, b  input  WIDTH  operands; two's complement for arithmetic ops.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: result  output  2*WIDTH  operation result.
REQ-011 SHALL have ports: div_by_zero, illegal_op  output  1 each  status, valid with out_valid.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY (mul/div only) -> DONE -> IDLE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; accept when in_valid && in_ready, registering op, a, b.
REQ-014 SHALL take single-cycle ops (all except mul/div) from IDLE straight to DONE: out_valid high on the first edge after acceptance.
REQ-015 SHALL compute mul iteratively (radix-2 Booth, one bit per cycle) in BUSY for exactly WIDTH cycles: out_valid at acceptance edge + WIDTH + 1.
REQ-016 SHALL compute div iteratively (non-restoring, one quotient bit per cycle) in BUSY for exactly WIDTH cycles, same latency as mul.
REQ-017 SHALL zero-extend single-cycle results into result[2*WIDTH-1:WIDTH]; add/sub wrap modulo 2^WIDTH.
REQ-018 SHALL shift logically for shr/shl by full unsigned b; b >= WIDTH gives 0.
REQ-019 SHALL rotate ror/rol by b mod WIDTH; amount 0 returns a.
REQ-020 SHALL ignore b for neg (two's complement of a) and not (bitwise invert of a).
REQ-021 SHALL return mul as the full signed 2*WIDTH product.
REQ-022 SHALL return div as {remainder, quotient}, signed, quotient truncated toward zero, remainder carrying the sign of a.
REQ-023 SHALL on div with b == 0 return quotient all-ones, remainder = a, div_by_zero = 1, and keep the full WIDTH-cycle latency.
REQ-024 SHALL on opcodes 1100-1111 complete as a single-cycle op with result 0 and illegal_op = 1.
REQ-025 SHALL in DONE hold result and flags stable while out_ready = 0; on out_valid && out_ready go to IDLE with out_valid low on the next cycle.
REQ-026 SHALL ignore in_valid and input changes while in BUSY or DONE.

Reset
REQ-027 SHALL on clr_n low immediately force state IDLE, out_valid 0, result 0, div_by_zero 0, illegal_op 0, iteration counter 0; in_ready 1 once clr_n is high.
REQ-028 SHALL abandon any in-flight mul/div on reset without producing a result.

Configuration
REQ-029 SHALL compile in the divider datapath when macro ALU_MC_DIV_EN is defined.
REQ-030 SHALL without ALU_MC_DIV_EN treat op 1001 as illegal: single-cycle, result 0, illegal_op = 1, div_by_zero = 0.

Verification
REQ-031 SHALL cover, WIDTH=32: add a=5, b=0xFFFFFFFD -> result 0x2, out_valid 1 cycle after acceptance.
REQ-032 SHALL cover: mul a=-7, b=6 -> result 0xFFFFFFFF_FFFFFFD6, out_valid exactly 33 cycles after acceptance.
REQ-033 SHALL cover: div a=-7, b=2 -> result {0xFFFFFFFF, 0xFFFFFFFD}; div a=10, b=0 -> {0x0000000A, 0xFFFFFFFF}, div_by_zero=1.
REQ-034 SHALL cover: ror a=0x80000001 by 1 and by 33 -> 0xC0000000 both; shl a=1, b=32 -> 0.
REQ-035 SHALL cover: out_ready held low 5 cycles after out_valid -> result stable, in_ready 0, new in_valid ignored.
REQ-036 SHALL cover: clr_n pulsed low at cycle 10 of a mul -> out_valid 0, in_ready 1 after release, next add correct.
